layer3_argmax: RTL and testbench
================================

LAYER3_ARGMAX -- requirements
Module: layer3_argmax

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 3, number of cycles to wait after start before sampling node outputs; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a classification; sampled on rising edge.
REQ-005 SHALL have ports: N0x..N15x  input  8 each  unsigned ReLU outputs of the 16 layer-3 nodes.
REQ-006 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-007 SHALL have port: done  output  1  single-cycle pulse marking a valid result.
REQ-008 SHALL have port: class_id  output  4  index of the winning node.
REQ-009 SHALL have port: class_max  output  8  value of the winning node.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, SCAN, DONE; the state register, counters and the snapshot are the only storage.
REQ-011 SHALL, in IDLE with start=1 at edge k, enter WAIT with the settle counter cleared.
REQ-012 SHALL ignore start in WAIT, SCAN and DONE; no queuing, no restart.
REQ-013 SHALL, in WAIT, increment the settle counter each edge and, at edge k+SETTLE_CYCLES, capture N0x..N15x into a 16x8 snapshot, load running max = N0x, running index = 0, and enter SCAN with scan index 1.
REQ-014 SHALL, in SCAN, compare one snapshot entry per cycle, indices 1..15 in order, over edges k+S+1..k+S+15.
REQ-015 SHALL replace the running max and index only when the entry is strictly greater (unsigned 8-bit compare); ties keep the lower index.
REQ-016 SHALL, at edge k+S+16, enter DONE, drive class_id/class_max from the running index and max, and set done=1.
REQ-017 SHALL, at edge k+S+17, return to IDLE with done=0; start is acted on again from that edge onward.
REQ-018 SHALL hold class_id and class_max stable between done pulses.
REQ-019 SHALL ignore input changes after the snapshot edge for the current classification.
REQ-020 SHALL keep the scan index within 1..15; no wrap past 15.

Reset
REQ-021 SHALL, on reset=1 at any edge, force state IDLE, busy=0, done=0, class_id=0, class_max=0, and clear all counters, the snapshot and the running max/index.
REQ-022 SHALL give reset priority over start and over any in-progress WAIT/SCAN/DONE activity.
REQ-023 SHALL produce no done pulse for a classification aborted by reset.

Verification
REQ-024 SHALL cover this scenario: after reset, start=1 for one cycle with all Nx=0 and S=3 -> done high for one cycle, 19 edges after the start edge; class_id=0, class_max=0; busy high for 19 cycles.
REQ-025 SHALL cover this scenario: N9x=8'd200, all other inputs less than 200 -> class_id=9, class_max=200.
REQ-026 SHALL cover this scenario: N4x=N11x=8'd150 as the maximum -> class_id=4, class_max=150 (tie rule); N15x=8'hFF with all others 8'hFE -> class_id=15, class_max=255 (unsigned compare).
REQ-027 SHALL cover this scenario: inputs changed one cycle after the snapshot edge (N2x 0->250) -> result reflects the pre-change values.
REQ-028 SHALL cover this scenario: a second start pulse during SCAN -> ignored; exactly one done pulse; start asserted in the cycle following DONE begins a new run.
REQ-029 SHALL cover this scenario: reset asserted at edge k+10 mid-SCAN -> busy=0, class_id=0, class_max=0 after that edge, no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/layer3_argmax.sv
// -----------------------------------------------------------------------------
// layer3_argmax
//   Picks the winning node of a 16-node ReLU layer. A start request waits
//   SETTLE_CYCLES edges for the node outputs to settle, snapshots all sixteen
//   values, then scans entries 1..15 one per cycle against a running maximum
//   seeded with entry 0. The result is published with a one-cycle done pulse
//   and held until the next pulse.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous active-high reset
//   start      : classification request, honoured only while idle
//   N0x..N15x  : 8-bit unsigned node outputs
//   busy       : high whenever the engine is not idle
//   done       : one-cycle pulse marking a fresh result
//   class_id   : index of the winning node (lowest index wins on a tie)
//   class_max  : value of the winning node
// -----------------------------------------------------------------------------
module layer3_argmax #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] N0x,
    input  logic [7:0] N1x,
    input  logic [7:0] N2x,
    input  logic [7:0] N3x,
    input  logic [7:0] N4x,
    input  logic [7:0] N5x,
    input  logic [7:0] N6x,
    input  logic [7:0] N7x,
    input  logic [7:0] N8x,
    input  logic [7:0] N9x,
    input  logic [7:0] N10x,
    input  logic [7:0] N11x,
    input  logic [7:0] N12x,
    input  logic [7:0] N13x,
    input  logic [7:0] N14x,
    input  logic [7:0] N15x,
    output logic       busy,
    output logic       done,
    output logic [3:0] class_id,
    output logic [7:0] class_max
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Settle counter value on the snapshot edge.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] settle_r;
    logic [3:0] scan_idx_r;
    logic       scan_end_r;     // entry 15 has been compared
    logic [7:0] snap_r [16];
    logic [7:0] run_max_r;
    logic [3:0] run_idx_r;
    logic [3:0] class_id_r;
    logic [7:0] class_max_r;

    logic [7:0] node_s [16];
    logic       settle_last_s;
    logic [7:0] entry_s;
    logic       entry_gt_s;

    assign node_s[0]  = N0x;
    assign node_s[1]  = N1x;
    assign node_s[2]  = N2x;
    assign node_s[3]  = N3x;
    assign node_s[4]  = N4x;
    assign node_s[5]  = N5x;
    assign node_s[6]  = N6x;
    assign node_s[7]  = N7x;
    assign node_s[8]  = N8x;
    assign node_s[9]  = N9x;
    assign node_s[10] = N10x;
    assign node_s[11] = N11x;
    assign node_s[12] = N12x;
    assign node_s[13] = N13x;
    assign node_s[14] = N14x;
    assign node_s[15] = N15x;

    assign settle_last_s = (settle_r == SETTLE_LAST);
    assign entry_s       = snap_r[scan_idx_r];
    // Strictly greater keeps the lower index on ties.
    assign entry_gt_s    = (entry_s > run_max_r);

    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign class_id  = class_id_r;
    assign class_max = class_max_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (settle_last_s) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SCAN: begin
                // One extra SCAN cycle after entry 15 publishes the result.
                if (scan_end_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counters, snapshot, running max/index and published result.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_r    <= 4'd0;
            scan_idx_r  <= 4'd0;
            scan_end_r  <= 1'b0;
            run_max_r   <= 8'd0;
            run_idx_r   <= 4'd0;
            class_id_r  <= 4'd0;
            class_max_r <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                snap_r[i] <= 8'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        settle_r <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (settle_last_s) begin
                        for (int i = 0; i < 16; i++) begin
                            snap_r[i] <= node_s[i];
                        end
                        run_max_r  <= node_s[0];
                        run_idx_r  <= 4'd0;
                        scan_idx_r <= 4'd1;
                        scan_end_r <= 1'b0;
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                ST_SCAN: begin
                    if (!scan_end_r) begin
                        if (entry_gt_s) begin
                            run_max_r <= entry_s;
                            run_idx_r <= scan_idx_r;
                        end
                        // Index parks at 15 rather than wrapping.
                        if (scan_idx_r == 4'd15) begin
                            scan_end_r <= 1'b1;
                        end else begin
                            scan_idx_r <= scan_idx_r + 4'd1;
                        end
                    end else begin
                        class_id_r  <= run_idx_r;
                        class_max_r <= run_max_r;
                    end
                end
                ST_DONE: begin
                    scan_end_r <= 1'b0;
                end
                default: begin
                    scan_end_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer3_argmax.sv
// -----------------------------------------------------------------------------
// tb_layer3_argmax
//   Self-checking bench for layer3_argmax. A timeline model (start edge plus
//   fixed offsets, argmax computed directly from the sampled inputs) predicts
//   busy/done/class_id/class_max every cycle; directed runs pin the model with
//   hand-computed results, then a randomized phase exercises start, input and
//   reset activity against the same model.
// -----------------------------------------------------------------------------
module tb_layer3_argmax;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] nx [16];
    logic       busy;
    logic       done;
    logic [3:0] class_id;
    logic [7:0] class_max;

    int n_checks = 0;
    int n_errors = 0;

    layer3_argmax #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start(start),
        .N0x(nx[0]),   .N1x(nx[1]),   .N2x(nx[2]),   .N3x(nx[3]),
        .N4x(nx[4]),   .N5x(nx[5]),   .N6x(nx[6]),   .N7x(nx[7]),
        .N8x(nx[8]),   .N9x(nx[9]),   .N10x(nx[10]), .N11x(nx[11]),
        .N12x(nx[12]), .N13x(nx[13]), .N14x(nx[14]), .N15x(nx[15]),
        .busy(busy), .done(done), .class_id(class_id), .class_max(class_max)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         edge_cnt = 0;
    bit         chk_en   = 1'b0;
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_t0     = 0;
    logic [11:0] m_best  = 12'd0;
    logic [3:0] m_id     = 4'd0;
    logic [7:0] m_max    = 8'd0;

    // First index holding the largest value, packed as {index, value}.
    function automatic logic [11:0] argmax_f(input logic [7:0] v [16]);
        int best_i = 0;
        for (int i = 1; i < 16; i++) begin
            if (v[i] > v[best_i]) best_i = i;
        end
        return {4'(best_i), v[best_i]};
    endfunction

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_id     <= 4'd0;
            m_max    <= 8'd0;
            chk_en   <= 1'b1;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_t0     <= edge_cnt + 1;
            end
        end else begin
            if (edge_cnt + 1 == m_t0 + S) m_best <= argmax_f(nx);
            if (edge_cnt + 1 == m_t0 + S + 16) begin
                m_id   <= m_best[11:8];
                m_max  <= m_best[7:0];
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
            if (edge_cnt + 1 == m_t0 + S + 17) m_active <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      32'(busy),      32'(m_active));
            check("done",      32'(done),      32'(m_done));
            check("class_id",  32'(class_id),  32'(m_id));
            check("class_max", 32'(class_max), 32'(m_max));
        end
    end

    // ---------------- directed run helper ----------------
    // poke_kind: 0 none, 1 set nx[poke_idx]=poke_val, 2 start pulse,
    //            3 reset pulse, 4 start in the cycle after done.
    // poke_at is the edge offset after the start edge at which the poke is
    // driven (it is sampled on the following edge).
    task automatic run_case(input int poke_at, input int poke_kind,
                            input int poke_idx, input logic [7:0] poke_val,
                            output int lat, output int busy_n, output int dones);
        int  s_edge;
        int  rel;
        bit  pend_start;
        lat = -1; busy_n = 0; dones = 0; pend_start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        s_edge = edge_cnt + 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            start = 1'b0;
            reset = 1'b0;
            rel = edge_cnt - s_edge;
            if (pend_start) begin
                start = 1'b1;
                pend_start = 1'b0;
            end
            if (done) begin
                dones++;
                if (lat < 0) lat = rel;
                if (poke_kind == 4 && dones == 1) pend_start = 1'b1;
            end else if (busy && lat < 0) begin
                busy_n++;
            end
            if (rel == poke_at) begin
                case (poke_kind)
                    1: nx[poke_idx] = poke_val;
                    2: start = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic fill_below(input int lim);
        for (int i = 0; i < 16; i++) nx[i] = 8'($urandom_range(0, lim - 1));
    endtask

    int lat, busy_n, dones;

    initial begin
        for (int i = 0; i < 16; i++) nx[i] = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_id",   32'(class_id), 32'd0);
        check("reset_max",  32'(class_max), 32'd0);

        // All zero: done 19 edges after the start edge, busy for 19 cycles.
        run_case(-1, 0, 0, 8'd0, lat, busy_n, dones);
        check("zero_latency", 32'(lat), 32'd19);
        check("zero_busy_cycles", 32'(busy_n), 32'd19);
        check("zero_dones", 32'(dones), 32'd1);
        check("zero_id", 32'(class_id), 32'd0);
        check("zero_max", 32'(class_max), 32'd0);

        // Single clear winner.
        fill_below(200); nx[9] = 8'd200;
        run_case(-1, 0, 0, 8'd0, lat, busy_n, dones);
        check("n9_id", 32'(class_id), 32'd9);
        check("n9_max", 32'(class_max), 32'd200);
        check("n9_model_pin", 32'(m_id), 32'd9);

        // Tie keeps the lower index.
        fill_below(150); nx[4] = 8'd150; nx[11] = 8'd150;
        run_case(-1, 0, 0, 8'd0, lat, busy_n, dones);
        check("tie_id", 32'(class_id), 32'd4);
        check("tie_max", 32'(class_max), 32'd150);

        // Unsigned compare at the top of the range.
        for (int i = 0; i < 16; i++) nx[i] = 8'hFE;
        nx[15] = 8'hFF;
        run_case(-1, 0, 0, 8'd0, lat, busy_n, dones);
        check("ff_id", 32'(class_id), 32'd15);
        check("ff_max", 32'(class_max), 32'd255);

        // Input change one cycle after the snapshot edge is not seen.
        fill_below(100); nx[2] = 8'd0; nx[7] = 8'd100;
        run_case(S, 1, 2, 8'd250, lat, busy_n, dones);
        check("late_change_id", 32'(class_id), 32'd7);
        check("late_change_max", 32'(class_max), 32'd100);

        // Second start during SCAN is ignored.
        fill_below(60); nx[12] = 8'd61;
        run_case(8, 2, 0, 8'd0, lat, busy_n, dones);
        check("restart_dones", 32'(dones), 32'd1);
        check("restart_id", 32'(class_id), 32'd12);

        // Start in the cycle after DONE begins a new run.
        fill_below(90); nx[3] = 8'd91;
        run_case(-1, 4, 0, 8'd0, lat, busy_n, dones);
        check("backtoback_dones", 32'(dones), 32'd2);
        check("backtoback_latency", 32'(lat), 32'd19);
        check("backtoback_id", 32'(class_id), 32'd3);

        // Reset at start edge + 10 aborts with no done pulse.
        fill_below(120); nx[6] = 8'd130;
        run_case(9, 3, 0, 8'd0, lat, busy_n, dones);
        check("abort_dones", 32'(dones), 32'd0);
        check("abort_busy_cycles", 32'(busy_n), 32'd10);
        check("abort_id", 32'(class_id), 32'd0);
        check("abort_max", 32'(class_max), 32'd0);

        // Normal run after the abort; all equal picks index 0.
        for (int i = 0; i < 16; i++) nx[i] = 8'd77;
        run_case(-1, 0, 0, 8'd0, lat, busy_n, dones);
        check("after_abort_dones", 32'(dones), 32'd1);
        check("after_abort_id", 32'(class_id), 32'd0);
        check("after_abort_max", 32'(class_max), 32'd77);

        // Randomized start / input / reset activity, checked per cycle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    nx[$urandom_range(0, 15)] = 8'($urandom);
                else
                    nx[$urandom_range(0, 15)] = 8'($urandom_range(250, 255));
            end
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (25) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
